// File: rtl/layer_4_pkg.sv
// Layer-4 feature-map constants, derived widths and packer FSM states.
package layer_4_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_CH     = 32;
  localparam int IMG_SIZE   = 104;
  localparam int BUS_WIDTH  = DATA_WIDTH * NUM_CH;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int POS_W      = $clog2(IMG_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;
endpackage

// File: rtl/layer_4_featuremap_packer_raster_counter.sv
// Column/row position of the pixel being assembled; wraps at the frame edge.
// Zero latency on last_col/last_pix, no backpressure (advance is a pulse).
module raster_counter #(
  parameter int IMG_SIZE = 104,
  parameter int W        = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] col,
  output logic [W-1:0] row,
  output logic         last_col,
  output logic         last_pix
);
  logic [W-1:0] col_q, col_d, row_q, row_d;

  assign col      = col_q;
  assign row      = row_q;
  assign last_col = (col_q == W'(IMG_SIZE - 1));
  assign last_pix = last_col && (row_q == W'(IMG_SIZE - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/layer_4_featuremap_packer.sv
// Packs NUM_CH serial fp32 activations into one pixel word; strobe one cycle after the
// last channel is accepted. No backpressure: every valid_in is consumed or flagged in err.
module layer_4_featuremap_packer #(
  parameter int DATA_WIDTH = layer_4_pkg::DATA_WIDTH,
  parameter int NUM_CH     = layer_4_pkg::NUM_CH,
  parameter int IMG_SIZE   = layer_4_pkg::IMG_SIZE
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           frame_start,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           valid_in,
  output logic [DATA_WIDTH*NUM_CH-1:0]   data_out,
  output logic                           valid_out,
  output logic [layer_4_pkg::POS_W-1:0]  col_out,
  output logic [layer_4_pkg::POS_W-1:0]  row_out,
  output logic                           eol_out,
  output logic                           eof_out,
  output logic                           busy,
  output logic                           err
);
  import layer_4_pkg::*;

  localparam int CW = $clog2(NUM_CH);

  state_e                               state_q, state_d;
  logic [CW-1:0]                        ch_q, ch_d, lane;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    asm_q, merged, data_q;
  logic [NUM_CH-1:0]                    lane_en;
  logic                                 filling, accept, done;
  logic                                 err_q, err_d;
  logic                                 valid_q, eol_q, eof_q;
  logic [POS_W-1:0]                     col, row, col_q, row_q;
  logic                                 last_col, last_pix;

  // The eof strobe cycle is treated as idle so the FSM can leave FILL one cycle later.
  assign filling = (state_q == FILL) && !eof_q;
  assign accept  = valid_in && (filling || frame_start);
  assign lane    = frame_start ? '0 : ch_q;
  assign done    = accept && (lane == CW'(NUM_CH - 1));

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lane_en[c] = accept && (lane == CW'(c));
      merged[c]  = lane_en[c] ? data_in : asm_q[c];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    err_d   = err_q;
    if (frame_start) begin
      state_d = FILL;
      ch_d    = valid_in ? CW'(1) : '0;
      if (filling) err_d = 1'b1;
    end else if (filling) begin
      if (valid_in) ch_d = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
    end else begin
      if (valid_in) err_d = 1'b1;
      if (state_q == FILL) state_d = IDLE;
    end
  end

  raster_counter #(
    .IMG_SIZE (IMG_SIZE),
    .W        (POS_W)
  ) u_raster (
    .clk      (Clk),
    .rst      (Rst),
    .advance  (done),
    .clear    (frame_start),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      valid_q <= done;
      eol_q   <= done && last_col;
      eof_q   <= done && last_pix;
      if (done) begin
        data_q <= merged;
        col_q  <= col;
        row_q  <= row;
      end
    end
  end

  // Lanes are fully overwritten before each use, so the assembly register needs no reset.
  always_ff @(posedge Clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (lane_en[c]) asm_q[c] <= data_in;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign col_out   = col_q;
  assign row_out   = row_q;
  assign eol_out   = eol_q;
  assign eof_out   = eof_q;
  assign busy      = (state_q == FILL);
  assign err       = err_q;
endmodule

// File: tb/tb_layer_4_featuremap_packer.sv
// Directed bench for the layer-4 packer; frame size reduced so a whole frame stays short.
module tb_layer_4_featuremap_packer;
  localparam int IMG = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          frame_start;
  logic [31:0]   data_in;
  logic          valid_in;
  logic [1023:0] data_out;
  logic          valid_out;
  logic [6:0]    col_out, row_out;
  logic          eol_out, eof_out, busy, err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1023:0] dat;
    logic [6:0]    col;
    logic [6:0]    row;
    logic          eol;
    logic          eof;
  } strobe_t;
  strobe_t sq[$];

  layer_4_featuremap_packer #(
    .DATA_WIDTH (32),
    .NUM_CH     (32),
    .IMG_SIZE   (IMG)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .frame_start (frame_start),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .col_out     (col_out),
    .row_out     (row_out),
    .eol_out     (eol_out),
    .eof_out     (eof_out),
    .busy        (busy),
    .err         (err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #1;
    if (valid_out) sq.push_back('{data_out, col_out, row_out, eol_out, eof_out});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_of(input logic [1023:0] d, input int c);
    return d[32*c +: 32];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic fs);
    data_in     = d;
    valid_in    = 1'b1;
    frame_start = fs;
    tick();
    valid_in    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_data"},  64'(data_out == '0), 64'd1);
    chk({tag, "_valid"}, 64'(valid_out), 64'd0);
    chk({tag, "_col"},   64'(col_out), 64'd0);
    chk({tag, "_row"},   64'(row_out), 64'd0);
    chk({tag, "_eol"},   64'(eol_out), 64'd0);
    chk({tag, "_eof"},   64'(eof_out), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_err"},   64'(err), 64'd0);
  endtask

  initial begin
    int nstrobe;
    Rst = 1'b1; frame_start = 1'b0; valid_in = 1'b0; data_in = '0;
    tick();
    tick();
    Rst = 1'b0;
    chk_idle_outputs("reset");

    // Word before frame start
    sq.delete();
    send(32'h1234_5678, 1'b0);
    tick();
    chk("pre_fs_strobes", 64'(sq.size()), 64'd0);
    chk("pre_fs_err", 64'(err), 64'd1);
    chk("pre_fs_busy", 64'(busy), 64'd0);
    do_reset();
    chk("pre_fs_err_cleared", 64'(err), 64'd0);

    // Single pixel
    pulse_fs();
    chk("single_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 31; c++) send(32'h3F80_0000 + 32'(c), 1'b0);
    chk("single_no_early_strobe", 64'(valid_out), 64'd0);
    send(32'h3F80_001F, 1'b0);
    chk("single_valid", 64'(valid_out), 64'd1);
    for (int c = 0; c < 32; c++)
      chk($sformatf("single_lane%0d", c), 64'(lane_of(data_out, c)), 64'(32'h3F80_0000 + 32'(c)));
    chk("single_col", 64'(col_out), 64'd0);
    chk("single_row", 64'(row_out), 64'd0);
    chk("single_err", 64'(err), 64'd0);
    tick();
    chk("single_strobe_1cyc", 64'(valid_out), 64'd0);
    chk("single_hold_lane3", 64'(lane_of(data_out, 3)), 64'h3F80_0003);

    // Frame start with data, issued while filling pixel (1,0)
    send(32'hDEAD_BEEF, 1'b1);
    chk("fsdata_err", 64'(err), 64'd1);
    for (int c = 1; c < 32; c++) send(32'h4000_0000 + 32'(c), 1'b0);
    chk("fsdata_valid", 64'(valid_out), 64'd1);
    chk("fsdata_lane0", 64'(lane_of(data_out, 0)), 64'hDEAD_BEEF);
    chk("fsdata_lane1", 64'(lane_of(data_out, 1)), 64'h4000_0001);
    chk("fsdata_lane31", 64'(lane_of(data_out, 31)), 64'h4000_001F);
    chk("fsdata_col", 64'(col_out), 64'd0);
    chk("fsdata_row", 64'(row_out), 64'd0);

    // Mid-pixel restart
    do_reset();
    pulse_fs();
    chk("restart_fs_idle_no_err", 64'(err), 64'd0);
    for (int c = 0; c < 10; c++) send(32'hAAAA_0000 + 32'(c), 1'b0);
    pulse_fs();
    chk("restart_err", 64'(err), 64'd1);
    sq.delete();
    for (int c = 0; c < 32; c++) send(32'h5555_0000 + 32'(c), 1'b0);
    chk("restart_valid", 64'(valid_out), 64'd1);
    for (int c = 0; c < 32; c++)
      chk($sformatf("restart_lane%0d", c), 64'(lane_of(data_out, c)), 64'(32'h5555_0000 + 32'(c)));
    chk("restart_col", 64'(col_out), 64'd0);
    chk("restart_row", 64'(row_out), 64'd0);

    // Full frame with random gaps
    do_reset();
    pulse_fs();
    sq.delete();
    for (int p = 0; p < IMG * IMG; p++) begin
      for (int c = 0; c < 32; c++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        send(32'(p << 8) | 32'(c), 1'b0);
      end
    end
    chk("frame_eof_valid", 64'(valid_out), 64'd1);
    chk("frame_eof", 64'(eof_out), 64'd1);
    chk("frame_busy_in_eof", 64'(busy), 64'd1);
    tick();
    chk("frame_busy_after", 64'(busy), 64'd0);
    chk("frame_eof_1cyc", 64'(eof_out), 64'd0);
    chk("frame_valid_after", 64'(valid_out), 64'd0);
    chk("frame_err", 64'(err), 64'd0);
    chk("frame_strobes", 64'(sq.size()), 64'(IMG * IMG));
    nstrobe = sq.size();
    for (int p = 0; p < IMG * IMG && p < nstrobe; p++) begin
      chk($sformatf("frame_col_p%0d", p), 64'(sq[p].col), 64'(p % IMG));
      chk($sformatf("frame_row_p%0d", p), 64'(sq[p].row), 64'(p / IMG));
      chk($sformatf("frame_eol_p%0d", p), 64'(sq[p].eol), 64'((p % IMG) == IMG - 1));
      chk($sformatf("frame_eof_p%0d", p), 64'(sq[p].eof), 64'(p == IMG * IMG - 1));
      chk($sformatf("frame_l0_p%0d", p), 64'(lane_of(sq[p].dat, 0)), 64'(32'(p << 8)));
      chk($sformatf("frame_l31_p%0d", p), 64'(lane_of(sq[p].dat, 31)), 64'(32'(p << 8) | 32'd31));
    end

    // Reset right after pixel (5,2)
    pulse_fs();
    for (int p = 0; p < 2 * IMG + 6; p++)
      for (int c = 0; c < 32; c++) send(32'hC000_0000 + 32'(c), 1'b0);
    chk("rstmid_valid", 64'(valid_out), 64'd1);
    chk("rstmid_col", 64'(col_out), 64'd5);
    chk("rstmid_row", 64'(row_out), 64'd2);
    do_reset();
    chk_idle_outputs("rstmid");
    pulse_fs();
    for (int c = 0; c < 32; c++) send(32'h0000_0100 + 32'(c), 1'b0);
    chk("rstmid_new_valid", 64'(valid_out), 64'd1);
    chk("rstmid_new_col", 64'(col_out), 64'd0);
    chk("rstmid_new_row", 64'(row_out), 64'd0);
    chk("rstmid_new_lane5", 64'(lane_of(data_out, 5)), 64'h0000_0105);
    chk("rstmid_new_err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/layer_4_featuremap_packer.md
# layer_4_featuremap_packer

Channel-serial to channel-parallel packer that feeds the layer-4 feature-map convolution banks. It accepts one 32-bit IEEE-754 activation per cycle, in channel-major order within each pixel and raster order across the frame. It assembles the 32 channels of each pixel into one 1024-bit word and pushes that word with a single-cycle `valid_out` strobe. This is the producer side of the `data_in`/`valid_in` bus consumed by every `layer_4_featuremap_*` instance. It also tracks pixel position and frame framing.

## Interface
- `DATA_WIDTH`, 32, width of one activation (fp32).
- `NUM_CH`, 32, channels packed per pixel; output width is `DATA_WIDTH*NUM_CH`.
- `IMG_SIZE`, 104, frame width and height in pixels.
- `Clk` input 1: single clock, all logic rising-edge.
- `Rst` input 1: synchronous, active-high reset.
- `frame_start` input 1: one-cycle pulse that opens a new frame.
- `data_in` input `DATA_WIDTH`: one channel activation.
- `valid_in` input 1: `data_in` is valid this cycle. No backpressure exists.
- `data_out` output `DATA_WIDTH*NUM_CH`: packed pixel. Channel c occupies bits [32c+31:32c].
- `valid_out` output 1: one-cycle strobe per packed pixel.
- `col_out` output 7: column of the pixel currently on `data_out`.
- `row_out` output 7: row of the pixel currently on `data_out`.
- `eol_out` output 1: asserted with `valid_out` when `col_out == IMG_SIZE-1`.
- `eof_out` output 1: asserted with `valid_out` on the last pixel of the frame.
- `busy` output 1: high while the FSM is in FILL.
- `err` output 1: sticky error flag. Cleared only by `Rst`.

## Operation
- The FSM has two states: IDLE and FILL. Reset state is IDLE.
- In IDLE:
  - `valid_in` without `frame_start` is dropped and sets `err`.
  - `frame_start` moves the FSM to FILL and clears the channel, column and row counters.
  - If `valid_in` is high in the same cycle as `frame_start`, that word is accepted as channel 0 of pixel (0,0).
- In FILL, each `valid_in` writes `data_in` into lane `ch` of the assembly register, then `ch` increments.
- When `ch == NUM_CH-1` is accepted:
  - The full word, with the final lane merged, is copied to the `data_out` register.
  - `col_out`, `row_out`, `eol_out` and `eof_out` are registered for that pixel.
  - `valid_out` is set for one cycle.
  - `ch` wraps to 0 and `col` increments.
  - At `col == IMG_SIZE-1`, `col` wraps to 0 and `row` increments.
- After the pixel at (`IMG_SIZE-1`, `IMG_SIZE-1`) is emitted, the FSM returns to IDLE.
- `frame_start` in FILL:
  - Restarts the counters at channel 0 of pixel (0,0) and discards the partial pixel.
  - Sets `err`.
  - A `valid_in` in the same cycle is taken as the new channel 0.
- `frame_start` in IDLE never sets `err`.
- Cycles without `valid_in` stall assembly. Gaps of any length are legal.
- The assembly register is not cleared between pixels. Every lane is overwritten before use.

## Timing
- Reset values: `data_out` = 0, `valid_out` = 0, `col_out` = 0, `row_out` = 0, `eol_out` = 0, `eof_out` = 0, `busy` = 0, `err` = 0. Counters are 0 and the FSM is in IDLE.
- Latency: last channel accepted at cycle N, so `valid_out` is high in cycle N+1.
- `data_out`, `col_out` and `row_out` hold their value until the next strobe.
- `eol_out` and `eof_out` are high only in strobe cycles.
- Throughput is at most one pixel per `NUM_CH` accepted words.
- `busy` is 1 from the cycle after `frame_start` until the cycle after the `eof_out` strobe.
- `Rst` mid-frame aborts immediately: outputs return to reset values on the next edge and there is no pending strobe.

## Structure
- Shared package `layer_4_pkg` holds:
  - `DATA_WIDTH`, `NUM_CH`, `IMG_SIZE` for layer 4.
  - The derived bus width and the counter widths (`$clog2`).
  - The FSM state enum {IDLE, FILL}.
- One natural sub-module, `raster_counter`, holds the column/row counters with wrap. It has inputs `advance` and `clear`, and outputs `col`, `row`, `last_col` and `last_pix`.
- The lane write is a decoded per-lane enable, not a shifter.

## Test plan
- **Single pixel:** after `frame_start`, feed values 0x3F800000+c for c = 0..31 on consecutive cycles. Require one `valid_out` one cycle after c = 31, with lane c equal to 0x3F800000+c, `col_out` = 0 and `row_out` = 0.
- **Full frame:** feed 104×104×32 words with random gaps. Require exactly 10816 strobes and raster-ordered `col_out`/`row_out`. Require `eol_out` on every col 103 and a single `eof_out` at (103,103). Require `busy` to fall afterward and `err` to stay 0.
- **Word before frame start:** with `valid_in` = 1 in IDLE and no `frame_start`, require no strobe and `err` = 1.
- **Frame start with data:** pulse `frame_start` together with `valid_in` = 0xDEADBEEF. Require lane 0 of the first packed word to be 0xDEADBEEF.
- **Mid-pixel restart:** after 10 channels, pulse `frame_start`, then feed 32 new words. Require the strobe to contain only the new words at (0,0), and `err` = 1.
- **Reset mid-frame:** assert `Rst` for 1 cycle after pixel (5,2). Require all outputs to be 0 the next cycle and the state to be IDLE. Require that a new frame starts cleanly at (0,0).
